stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes, a registered output stage and two selection modes: fixed, where an external select chooses the channel, and round-robin arbitration. It succeeds the team's combinational 1-bit 4:1 data selector. It sits between several producer streams and one consumer, and gives full throughput with one cycle of latency.

---
 rtl/stream_mux_rr.sv | 156 +++++++++++++++
 tb/tb_stream_mux_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, WIDTH-bit valid/ready stream multiplexer with a
// registered output stage. Selection is either fixed (external sel) or
// round-robin arbitration; one cycle of latency, one beat per cycle.
//
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN
//   Adds in_last/out_last and holds round-robin arbitration on a channel
//   until the beat carrying in_last=1 has been transferred.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    CH*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   in_last    per-channel end-of-packet      (lock build only)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel select for fixed mode; values >= CH select nothing
//   out_data   registered output data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the held beat
//   out_last   registered end-of-packet       (lock build only)
//   grant      source channel of the held beat
module stream_mux_rr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [CH-1:0]       in_last,
  output logic                out_last,
`endif
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SELW-1:0]     grant
);

  logic [WIDTH-1:0] ch_data [CH];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_nxt;
  logic [SELW-1:0]  rr_idx;
  logic             rr_found;
  logic [SELW-1:0]  chosen;
  logic             chosen_ok;
  logic             load;
  logic             xfer;
  logic             rr_adv;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             locked;
  logic [SELW-1:0]  lock_ch;
`endif

  // Unpack the flat input bus into per-channel words.
  for (genvar g = 0; g < CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Round-robin scan: walk offsets from farthest to nearest so the channel
  // closest to ptr (in wrap order) is the last, and winning, assignment.
  always_comb begin
    int unsigned idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = 0;
    for (int unsigned k = 0; k < CH; k++) begin
      idx = 32'(ptr) + (CH - 1 - k);
      if (idx >= CH) idx = idx - CH;
      if (in_valid[SELW'(idx)]) begin
        rr_found = 1'b1;
        rr_idx   = SELW'(idx);
      end
    end
  end

  // Channel selection for this cycle.
  always_comb begin
    chosen    = sel;
    chosen_ok = (32'(sel) < CH);
    if (mode) begin
      chosen    = rr_idx;
      chosen_ok = rr_found;
`ifdef STREAM_MUX_PKT_LOCK_EN
      // Mid-packet: stay on the locked channel regardless of other requests.
      if (locked) begin
        chosen    = lock_ch;
        chosen_ok = 1'b1;
      end
`endif
    end
  end

  assign load = !out_valid | out_ready;
  assign xfer = chosen_ok & in_valid[chosen] & load & !rst;

  // Explicit wrap keeps the pointer legal for non-power-of-two CH.
  assign ptr_nxt = (chosen == SELW'(CH - 1)) ? '0 : chosen + SELW'(1);

`ifdef STREAM_MUX_PKT_LOCK_EN
  assign rr_adv = in_last[chosen];
`else
  assign rr_adv = 1'b1;
`endif

  // Ready is offered only to the chosen channel, and never during reset.
  always_comb begin
    in_ready = '0;
    if (!rst && chosen_ok && load) in_ready[chosen] = 1'b1;
  end

  // Output register and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_data  <= ch_data[chosen];
        grant     <= chosen;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && mode && rr_adv) ptr <= ptr_nxt;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  // Packet lock and registered end-of-packet flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_ch  <= '0;
      out_last <= 1'b0;
    end else begin
      if (xfer) out_last <= in_last[chosen];
      if (!mode) begin
        locked <= 1'b0;
      end else if (xfer) begin
        locked  <= !in_last[chosen];
        lock_ch <= chosen;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CH    = 4;
  localparam int unsigned SELW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [SELW-1:0]     grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [CH-1:0]       in_last;
  logic                out_last;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant)
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_g;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic m, input logic [1:0] s,
                             input logic [3:0] vv, input logic orr, input logic [31:0] d,
                             input logic [3:0] eir, input logic eov, input logic [7:0] eod,
                             input logic [1:0] eg);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.vld = vv; t.ordy = orr; t.data = d;
    t.e_ir = eir; t.e_ov = eov; t.e_od = eod; t.e_g = eg;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic m, input logic [1:0] s,
                       input logic [3:0] vv, input logic orr, input logic [31:0] d);
    rst = r; mode = m; sel = s; in_valid = vv; out_ready = orr; in_data = d;
  endtask

  // Reference model state: the held beat and the round-robin pointer.
  logic       m_valid;
  logic [7:0] m_data;
  int         m_grant;
  int         m_ptr;

  // Channel the spec's rules pick: sel in fixed mode, otherwise the valid
  // channel at the smallest wrap distance from the pointer. -1 = none.
  function automatic int model_pick(input logic m, input logic [1:0] s, input logic [3:0] vv);
    int best, bestd, d;
    if (!m) return (int'(s) < CH) ? int'(s) : -1;
    best = -1; bestd = CH;
    for (int i = 0; i < CH; i++) begin
      d = (i - m_ptr + CH) % CH;
      if (vv[i] && d < bestd) begin bestd = d; best = i; end
    end
    return best;
  endfunction

  initial begin
    logic [3:0] exp_ir;
    logic       ld, xf;
    int         pk;

    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 32'h13121110);
`ifdef STREAM_MUX_PKT_LOCK_EN
    in_last = '1;
`endif

    // rst mode sel vld ordy data | in_ready out_valid out_data grant
    tbl.push_back(v(1, 1, 0, 4'hF, 1, 32'h13121110, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(v(1, 1, 0, 4'hF, 1, 32'h13121110, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 2, 4'b0100, 1, 32'h00A50000, 4'b0100, 1, 8'hA5, 2));
    tbl.push_back(v(0, 0, 2, 4'b1111, 1, 32'h003C0000, 4'b0100, 1, 8'h3C, 2));
    tbl.push_back(v(0, 0, 2, 4'b0000, 1, 32'h00000000, 4'b0100, 0, 8'h3C, 2));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b0100, 1, 8'h12, 2));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(v(0, 1, 0, 4'b1010, 1, 32'h13121110, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(v(0, 1, 0, 4'b1010, 1, 32'h13121110, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(v(0, 1, 0, 4'b1010, 1, 32'h13121110, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(v(0, 1, 0, 4'b1010, 1, 32'h13121110, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(v(0, 0, 0, 4'b0001, 1, 32'h00000077, 4'b0001, 1, 8'h77, 0));
    tbl.push_back(v(0, 0, 0, 4'hF, 0, 32'h13121110, 4'b0000, 1, 8'h77, 0));
    tbl.push_back(v(0, 0, 0, 4'hF, 0, 32'h13121110, 4'b0000, 1, 8'h77, 0));
    tbl.push_back(v(0, 0, 0, 4'hF, 0, 32'h13121110, 4'b0000, 1, 8'h77, 0));
    tbl.push_back(v(0, 0, 0, 4'b0001, 1, 32'h00000055, 4'b0001, 1, 8'h55, 0));
    tbl.push_back(v(0, 1, 0, 4'hF, 0, 32'h13121110, 4'b0000, 1, 8'h55, 0));
    tbl.push_back(v(0, 0, 3, 4'hF, 0, 32'h13121110, 4'b0000, 1, 8'h55, 0));
    tbl.push_back(v(0, 0, 3, 4'b1000, 1, 32'h13121110, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b0100, 1, 8'h12, 2));
    tbl.push_back(v(1, 1, 0, 4'hF, 1, 32'h13121110, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 0, 4'hF, 1, 32'h13121110, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(v(0, 1, 0, 4'b0000, 1, 32'h13121110, 4'b0000, 0, 8'h10, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].mode, tbl[i].sel, tbl[i].vld, tbl[i].ordy, tbl[i].data);
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].e_g));
    end

    // Throughput: all channels valid, consumer always ready -> one beat per cycle in rotation.
    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 32'h13121110);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 32'h13121110);
      #1;
      chk($sformatf("tput%0d in_ready", k), 32'(in_ready), 32'(1) << (k % 4));
      @(posedge clk); #1;
      chk($sformatf("tput%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("tput%0d grant", k), 32'(grant), 32'(k % 4));
      chk($sformatf("tput%0d out_data", k), 32'(out_data), 32'h10 + 32'(k % 4));
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: ch1 sends 3 beats while ch2 stays valid.
    drive(1'b1, 1'b1, 2'd0, 4'h0, 1'b1, 32'h0);
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 1'b1, 2'd0, 4'b0110, 1'b1, {8'h00, 8'h99, 8'(8'h20 + b), 8'h00});
      in_last = (b == 2) ? 4'b0110 : 4'b0100;
      #1;
      chk($sformatf("lock%0d in_ready", b), 32'(in_ready), (b < 3) ? 32'b0010 : 32'b0100);
      @(posedge clk); #1;
      chk($sformatf("lock%0d grant", b), 32'(grant), (b < 3) ? 32'd1 : 32'd2);
      chk($sformatf("lock%0d out_data", b), 32'(out_data), (b < 3) ? 32'h20 + 32'(b) : 32'h99);
      chk($sformatf("lock%0d out_last", b), 32'(out_last), (b >= 2) ? 32'd1 : 32'd0);
    end
    in_last = '1;
`endif

    // Randomized phase against the reference model.
    drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 32'h0);
    @(posedge clk); #1;
    m_valid = 1'b0; m_data = 8'h00; m_grant = 0; m_ptr = 0;
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom), ($urandom_range(0, 3) != 0), $urandom);
      #1;
      ld = !m_valid || out_ready;
      pk = model_pick(mode, sel, in_valid);
      exp_ir = 4'b0000;
      if (!rst && ld && pk >= 0) exp_ir[pk] = 1'b1;
      xf = !rst && ld && pk >= 0 && in_valid[pk];
      chk($sformatf("rand%0d in_ready", n), 32'(in_ready), 32'(exp_ir));
      if (rst) begin
        m_valid = 1'b0; m_data = 8'h00; m_grant = 0; m_ptr = 0;
      end else if (xf) begin
        m_valid = 1'b1; m_data = in_data[pk*8 +: 8]; m_grant = pk;
        if (mode) m_ptr = (pk + 1) % CH;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("rand%0d out_valid", n), 32'(out_valid), 32'(m_valid));
      chk($sformatf("rand%0d out_data", n), 32'(out_data), 32'(m_data));
      chk($sformatf("rand%0d grant", n), 32'(grant), 32'(m_grant));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
